char_buffer_sequencer: RTL and testbench

CHAR_BUFFER_SEQUENCER -- requirements
Module: char_buffer_sequencer

---
 rtl/char_buffer_sequencer_if.sv | 32 +++
 rtl/char_buffer_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_char_buffer_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_buffer_sequencer_if.sv
// Bundle for the character buffer sequencer: host write port, op request
// handshake, shared character memory port and status flags.
interface char_buffer_sequencer_if;
  // Op handshake: a request is taken on a cycle with op_valid && op_ready;
  // op_code/op_start_addr matter only then, and a request seen while
  // op_ready is low is dropped, not held.
  logic [7:0] hw_char;
  logic [9:0] hw_addr;
  logic       hw_wen;
  logic       op_valid;
  logic [1:0] op_code;
  logic [9:0] op_start_addr;
  logic       op_ready;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wen;
  logic       mem_ren;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       op_done;
  logic       hw_overflow;

  modport slave (
    input  hw_char, hw_addr, hw_wen, op_valid, op_code, op_start_addr, mem_rdata,
    output op_ready, mem_addr, mem_wdata, mem_wen, mem_ren, busy, op_done, hw_overflow
  );

  modport master (
    output hw_char, hw_addr, hw_wen, op_valid, op_code, op_start_addr, mem_rdata,
    input  op_ready, mem_addr, mem_wdata, mem_wen, mem_ren, busy, op_done, hw_overflow
  );
endinterface

// File: rtl/char_buffer_sequencer.sv
// Shares a 64x16 character memory between single host writes and an erase/scroll engine.
// Macro CHAR_BUFFER_SCROLL_EN builds the scroll engine (SCRL_RD/SCRL_WR).
module char_buffer_sequencer (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          px_clk,
  char_buffer_sequencer_if.slave        bus,
  output logic [1:0]                    dbg_state
);

`ifdef CHAR_BUFFER_SCROLL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, SCRL_RD = 2'd2, SCRL_WR = 2'd3} state_t;
  localparam logic [9:0] SCRL_LAST = 10'd959;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1} state_t;
`endif

  localparam logic [9:0] LAST_ADDR = 10'd1023;
  localparam logic [9:0] ROW_STEP  = 10'd64;
  localparam logic [7:0] BLANK     = 8'h20;

  state_t     state;
  logic       busy;
  logic       op_done;
  logic       hw_overflow;
  logic [9:0] cnt;
  logic [9:0] last;
  logic       hold_full;
  logic [7:0] hold_char;
  logic [9:0] hold_addr;
`ifdef CHAR_BUFFER_SCROLL_EN
  logic [7:0] rd_data;
  logic       rd_pend;
`else
  logic       nop;
  logic       unused_rdata;
  assign unused_rdata = ^bus.mem_rdata;
`endif

  logic slot;
  logic host_issue;
  logic eng_req;
  logic eng_grant;

  // The held host write owns any slot it wants; the engine only gets free slots.
  always_comb begin
    slot       = ~px_clk;
    host_issue = slot & hold_full;
    eng_req    = 1'b0;
    case (state)
`ifdef CHAR_BUFFER_SCROLL_EN
      FILL:    eng_req = 1'b1;
      SCRL_RD: eng_req = 1'b1;
      SCRL_WR: eng_req = ~rd_pend;
`else
      FILL:    eng_req = ~nop;
`endif
      default: eng_req = 1'b0;
    endcase
    eng_grant = slot & ~hold_full & eng_req;

    bus.mem_wen   = 1'b0;
    bus.mem_ren   = 1'b0;
    bus.mem_addr  = cnt;
    bus.mem_wdata = BLANK;
    if (host_issue) begin
      bus.mem_wen   = 1'b1;
      bus.mem_addr  = hold_addr;
      bus.mem_wdata = hold_char;
    end else if (eng_grant) begin
`ifdef CHAR_BUFFER_SCROLL_EN
      if (state == SCRL_RD) begin
        bus.mem_ren  = 1'b1;
        bus.mem_addr = cnt + ROW_STEP;
      end else begin
        bus.mem_wen = 1'b1;
        if (state == SCRL_WR) bus.mem_wdata = rd_data;
      end
`else
      bus.mem_wen = 1'b1;
`endif
    end
  end

  assign bus.op_ready    = ~busy;
  assign bus.busy        = busy;
  assign bus.op_done     = op_done;
  assign bus.hw_overflow = hw_overflow;
  assign dbg_state       = state;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      op_done     <= 1'b0;
      hw_overflow <= 1'b0;
      cnt         <= '0;
      last        <= '0;
      hold_full   <= 1'b0;
      hold_char   <= '0;
      hold_addr   <= '0;
`ifdef CHAR_BUFFER_SCROLL_EN
      rd_data     <= '0;
      rd_pend     <= 1'b0;
`else
      nop         <= 1'b0;
`endif
    end else begin
      op_done <= 1'b0;

      // A newer write replaces one that has not gone out yet.
      if (bus.hw_wen) begin
        hold_full <= 1'b1;
        hold_char <= bus.hw_char;
        hold_addr <= bus.hw_addr;
        if (hold_full && !host_issue) hw_overflow <= 1'b1;
      end else if (host_issue) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            busy <= 1'b1;
            case (bus.op_code)
              2'd0: begin
                cnt   <= bus.op_start_addr;
                last  <= {bus.op_start_addr[9:6], 6'h3f};
                state <= FILL;
              end
              2'd1: begin
                cnt   <= bus.op_start_addr;
                last  <= LAST_ADDR;
                state <= FILL;
              end
              2'd2: begin
`ifdef CHAR_BUFFER_SCROLL_EN
                cnt   <= '0;
                last  <= SCRL_LAST;
                state <= SCRL_RD;
`else
                nop   <= 1'b1;
                state <= FILL;
`endif
              end
              default: begin
                cnt   <= '0;
                last  <= LAST_ADDR;
                state <= FILL;
              end
            endcase
          end
        end
        FILL: begin
`ifndef CHAR_BUFFER_SCROLL_EN
          // Scroll request without the scroll engine: one idle busy cycle.
          if (nop) begin
            nop     <= 1'b0;
            state   <= IDLE;
            busy    <= 1'b0;
            op_done <= 1'b1;
          end else
`endif
          if (eng_grant) begin
            if (cnt == last) begin
              state   <= IDLE;
              busy    <= 1'b0;
              op_done <= 1'b1;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
        end
`ifdef CHAR_BUFFER_SCROLL_EN
        SCRL_RD: begin
          if (eng_grant) begin
            rd_pend <= 1'b1;
            state   <= SCRL_WR;
          end
        end
        SCRL_WR: begin
          // Read data is valid the cycle after the read slot.
          if (rd_pend) begin
            rd_data <= bus.mem_rdata;
            rd_pend <= 1'b0;
          end else if (eng_grant) begin
            cnt <= cnt + 10'd1;
            if (cnt == last) begin
              last  <= LAST_ADDR;
              state <= FILL;
            end else begin
              state <= SCRL_RD;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_buffer_sequencer.sv
// Directed-plus-random bench for char_buffer_sequencer with a memory model,
// host-write slot model and an expected engine-write queue.
module tb_char_buffer_sequencer;
  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       px_clk = 1'b1;
  logic [1:0] dbg_state;
  logic       px_hold = 1'b0;
  logic       px_val = 1'b1;
  logic       bd_clear = 1'b0;
  logic       bd_preload = 1'b0;

  char_buffer_sequencer_if bus();

  char_buffer_sequencer dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .px_clk    (px_clk),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Character memory: synchronous write and read.
  logic [7:0] mem [0:1023];
  logic [7:0] hello [0:4] = '{8'h48, 8'h45, 8'h4c, 8'h4c, 8'h4f};

  always @(posedge clk) begin
    if (bd_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (bd_preload) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= (i >= 64 && i < 69) ? hello[i-64] : 8'($urandom);
    end else if (bus.mem_wen) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected engine writes {addr,data} in issue order.
  logic [17:0] exp_q[$];
  int   cyc = 0;
  int   eng_cnt = 0;
  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   viol = 0;
  int   last_eng = -10;
  logic host_pend = 1'b0;
  logic [9:0] h_addr = '0;
  logic [7:0] h_char = '0;
  logic exp_ovf = 1'b0;
  logic done_timing = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if ((bus.mem_wen || bus.mem_ren) && px_clk) viol++;
    if (bus.mem_wen && bus.mem_ren) viol++;
    if (!clr_n) begin
      host_pend = 1'b0;
      exp_ovf   = 1'b0;
      if (bus.mem_wen || bus.mem_ren) viol++;
    end else begin
      if (host_pend && !px_clk) begin
        chk("host_wr", {13'd0, bus.mem_wen, bus.mem_addr, bus.mem_wdata},
                       {13'd0, 1'b1, h_addr, h_char});
        host_pend = 1'b0;
      end else if (bus.mem_wen) begin
        if (exp_q.size() == 0) chk("eng_wr_extra", exp_q.size(), 1);
        else chk("eng_wr", {14'd0, bus.mem_addr, bus.mem_wdata}, {14'd0, exp_q.pop_front()});
        eng_cnt++;
        last_eng = cyc;
      end
      if (bus.mem_ren) rd_cnt++;
      if (bus.op_done) begin
        done_cnt++;
        if (done_timing) chk("done_lat", cyc, last_eng + 1);
      end
      if (bus.hw_wen) begin
        if (host_pend) exp_ovf = 1'b1;
        host_pend = 1'b1;
        h_addr    = bus.hw_addr;
        h_char    = bus.hw_char;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    px_clk        = px_hold ? px_val : 1'($urandom_range(0, 1));
    bus.hw_wen    = 1'b0;
    bus.op_valid  = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] code, input logic [9:0] start);
    tick();
    bus.op_valid      = 1'b1;
    bus.op_code       = code;
    bus.op_start_addr = start;
    @(negedge clk);
    chk("op_ready_pre", bus.op_ready, 1);
    tick();
    @(negedge clk);
    chk("busy_rise", bus.busy, 1);
    chk("ready_low", bus.op_ready, 0);
    chk("done_early", bus.op_done, 0);
  endtask

  task automatic wait_done(input int budget, input bit host_rand, input int poke_at,
                           input int inject_at);
    int base;
    bit injected;
    bit seen;
    base = eng_cnt;
    injected = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (host_rand && $urandom_range(0, 7) == 0) begin
        bus.hw_wen  = 1'b1;
        bus.hw_addr = 10'($urandom_range(0, 1023));
        bus.hw_char = 8'($urandom_range(0, 255));
      end
      if (i == poke_at) begin
        bus.op_valid      = 1'b1;
        bus.op_code       = 2'd3;
        bus.op_start_addr = 10'd0;
      end
      if (!injected && inject_at >= 0 && eng_cnt - base >= inject_at) begin
        bus.hw_wen  = 1'b1;
        bus.hw_addr = 10'h200;
        bus.hw_char = 8'h41;
        injected    = 1'b1;
      end
      @(negedge clk);
      if (bus.op_done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic run_fill(input logic [1:0] code, input logic [9:0] start, input bit host_rand,
                          input int poke_at, input int inject_at);
    int lo, hi, base_eng, base_done;
    lo = (code == 2'd3) ? 0 : int'(start);
    hi = (code == 2'd0) ? (int'(start) / 64) * 64 + 63 : 1023;
    exp_q.delete();
    for (int a = lo; a <= hi; a++) exp_q.push_back({10'(a), 8'h20});
    base_eng  = eng_cnt;
    base_done = done_cnt;
    start_op(code, start);
    wait_done(20000, host_rand, poke_at, inject_at);
    repeat (4) tick();
    @(negedge clk);
    chk("eng_cnt", eng_cnt - base_eng, hi - lo + 1);
    chk("exp_q_left", exp_q.size(), 0);
    chk("done_cnt", done_cnt - base_done, 1);
    chk("ready_idle", bus.op_ready, 1);
    chk("ovf", bus.hw_overflow, exp_ovf);
  endtask

  initial begin
    int base_eng, base_done, base_rd, bad_row;
    bus.hw_wen = 1'b0; bus.hw_addr = '0; bus.hw_char = '0;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_start_addr = '0;
    bd_clear = 1'b1;
    tick();
    bd_clear = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_ready", bus.op_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.op_done, 0);
    chk("rst_ovf", bus.hw_overflow, 0);
    chk("rst_wen", bus.mem_wen, 0);
    chk("rst_ren", bus.mem_ren, 0);
    tick();
    clr_n = 1'b1;
    @(negedge clk);
    chk("rel_wen", bus.mem_wen, 0);
    chk("rel_ren", bus.mem_ren, 0);

    // Two back-to-back host writes with no slot between them.
    px_hold = 1'b1; px_val = 1'b1;
    tick(); bus.hw_wen = 1'b1; bus.hw_addr = 10'h011; bus.hw_char = 8'h58;
    tick(); bus.hw_wen = 1'b1; bus.hw_addr = 10'h012; bus.hw_char = 8'h59;
    tick();
    @(negedge clk);
    chk("ovf_set", bus.hw_overflow, 1);
    px_val = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("ovf_second", mem[10'h012], 8'h59);
    chk("ovf_first_lost", mem[10'h011], 8'h00);
    px_hold = 1'b0;

    tick(); clr_n = 1'b0;
    #1 chk("ovf_clr", bus.hw_overflow, 0);
    tick(); tick(); clr_n = 1'b1;

    run_fill(2'd0, 10'h105, 1'b0, -1, -1);
    run_fill(2'd0, 10'($urandom_range(0, 1023)), 1'b1, -1, -1);
    run_fill(2'd1, 10'($urandom_range(700, 1000)), 1'b1, 20, -1);
    run_fill(2'd3, 10'h3a5, 1'b0, -1, 100);

`ifdef CHAR_BUFFER_SCROLL_EN
    bd_preload = 1'b1;
    tick();
    bd_preload = 1'b0;
    tick();
    exp_q.delete();
    for (int d = 0; d < 960; d++) exp_q.push_back({10'(d), mem[d+64]});
    for (int d = 960; d < 1024; d++) exp_q.push_back({10'(d), 8'h20});
    base_eng = eng_cnt; base_done = done_cnt; base_rd = rd_cnt;
    start_op(2'd2, 10'h000);
    wait_done(30000, 1'b0, -1, -1);
    repeat (3) tick();
    @(negedge clk);
    chk("scrl_writes", eng_cnt - base_eng, 1024);
    chk("scrl_reads", rd_cnt - base_rd, 960);
    chk("scrl_done", done_cnt - base_done, 1);
    for (int i = 0; i < 5; i++) chk("row0_hello", mem[i], hello[i]);
    bad_row = 0;
    for (int i = 960; i < 1024; i++) if (mem[i] !== 8'h20) bad_row++;
    chk("row15_blank", bad_row, 0);
`else
    done_timing = 1'b0;
    base_eng = eng_cnt; base_done = done_cnt;
    start_op(2'd2, 10'($urandom_range(0, 1023)));
    tick();
    @(negedge clk);
    chk("nop_done", bus.op_done, 1);
    chk("nop_busy", bus.busy, 0);
    tick();
    @(negedge clk);
    chk("nop_done_once", bus.op_done, 0);
    done_timing = 1'b1;
    chk("nop_done_cnt", done_cnt - base_done, 1);
    chk("nop_no_wr", eng_cnt - base_eng, 0);
`endif

    // Reset in the middle of a clear-screen operation.
    exp_q.delete();
    for (int a = 0; a < 1024; a++) exp_q.push_back({10'(a), 8'h20});
    start_op(2'd3, 10'h000);
    base_eng = eng_cnt;
    for (int i = 0; i < 5000 && (eng_cnt - base_eng) < 100; i++) begin
      tick();
      @(negedge clk);
    end
    chk("abort_reached", (eng_cnt - base_eng) >= 100, 1);
    tick();
    clr_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_wen", bus.mem_wen, 0);
    chk("abort_ready", bus.op_ready, 1);
    chk("abort_busy", bus.busy, 0);
    base_eng = eng_cnt; base_done = done_cnt;
    repeat (3) tick();
    tick();
    clr_n = 1'b1;
    @(negedge clk);
    chk("abort_rel_wen", bus.mem_wen, 0);
    repeat (50) tick();
    @(negedge clk);
    chk("abort_no_wr", eng_cnt - base_eng, 0);
    chk("abort_no_done", done_cnt - base_done, 0);
    chk("abort_ready_end", bus.op_ready, 1);

    chk("protocol", viol, 0);
`ifndef CHAR_BUFFER_SCROLL_EN
    chk("no_ren", rd_cnt, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
